// File: rtl/inv_pipe.sv
// Pipelined polarity/edge stage: per-beat transform (pass, masked invert, edge
// detect, alternating invert) carried through DEPTH valid/ready registered stages.
module inv_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       cfg_mode,
   input  logic [WIDTH-1:0] cfg_mask,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   localparam logic [1:0] MODE_PASS = 2'd0;
   localparam logic [1:0] MODE_INV  = 2'd1;
   localparam logic [1:0] MODE_EDGE = 2'd2;
   localparam logic [1:0] MODE_ALT  = 2'd3;

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] sd [DEPTH];
   logic [DEPTH-1:0] can_load;
   logic [WIDTH-1:0] prev;
   logic             phase;
   logic             accept;
   logic [WIDTH-1:0] y_c;

   // A stage can load when the consumer takes a beat or any stage from it to the
   // output is empty; this flattens the ready chain into one term per stage.
   for (genvar i = 0; i < DEPTH; i++) begin : g_can_load
      assign can_load[i] = out_ready | ~(&v[DEPTH-1:i]);
   end

   assign in_ready = can_load[0];
   assign accept   = in_valid & in_ready;

   // Transform of the beat being accepted this cycle
   always_comb begin
      y_c = in_data;
      case (cfg_mode)
         MODE_PASS: y_c = in_data;
         MODE_INV:  y_c = in_data ^ cfg_mask;
         MODE_EDGE: y_c = in_data ^ prev;
         MODE_ALT:  y_c = in_data ^ (cfg_mask & {WIDTH{phase}});
         default:   y_c = in_data;
      endcase
   end

   // Edge history and alternation phase advance on every accept, whatever the mode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev  <= '0;
         phase <= 1'b0;
      end else if (accept) begin
         prev  <= in_data;
         phase <= ~phase;
      end
   end

   // Stage registers; data only moves with a valid beat so an empty stage keeps its last word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            sd[i] <= '0;
         end
      end else begin
         if (can_load[0]) begin
            v[0] <= accept;
            if (accept) begin
               sd[0] <= y_c;
            end
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (can_load[i]) begin
               v[i] <= v[i-1];
               if (v[i-1]) begin
                  sd[i] <= sd[i-1];
               end
            end
         end
      end
   end

   assign out_valid = v[DEPTH-1];
   assign out_data  = sd[DEPTH-1];
   assign busy      = |v;

endmodule

// File: tb/tb_inv_pipe.sv
// Directed and randomised self-checking bench for inv_pipe (WIDTH=8, DEPTH=2).
module tb_inv_pipe;

   localparam logic [1:0] PASS = 2'd0;
   localparam logic [1:0] INV  = 2'd1;
   localparam logic [1:0] EDGE = 2'd2;
   localparam logic [1:0] ALT  = 2'd3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] cfg_mode = PASS;
   logic [7:0] cfg_mask = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       busy;

   int tests = 0;
   int failed = 0;
   int cyc = 0;
   int last_acc_edge = 0;
   logic [7:0] got[$];
   int got_edge[$];

   inv_pipe #(.WIDTH(8), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_mask(cfg_mask),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Delivery monitor: inputs only change just after posedge, so negedge sees what the edge will use
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         got.push_back(out_data);
         got_edge.push_back(cyc + 1);
      end
   end

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      got.delete();
      got_edge.delete();
   endtask

   // Called just after a posedge; returns just after the accepting posedge, in_valid left high
   task automatic send(input logic [1:0] m, input logic [7:0] mk, input logic [7:0] dd);
      int n = 0;
      cfg_mode = m; cfg_mask = mk; in_data = dd; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) begin
         tests++; failed++;
         $display("FAIL send_timeout: data %h never accepted", dd);
      end
      last_acc_edge = cyc + 1;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic check_seq(input string name, input logic [7:0] exp[]);
      tests++;
      if (got.size() !== exp.size()) begin
         failed++;
         $display("FAIL %s_count: got %0d beats, expected %0d", name, got.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         tests++;
         if (got[i] !== exp[i]) begin
            failed++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, i, got[i], exp[i]);
         end
      end
   endtask

   task automatic test_reset();
      #1;
      tests++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
         failed++;
         $display("FAIL reset_state: ov=%b od=%h busy=%b ir=%b, expected 0 00 0 1",
                  out_valid, out_data, busy, in_ready);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      out_ready = 1'b0;
      send(PASS, 8'h00, 8'hAA);
      send(PASS, 8'h00, 8'hBB);
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || out_data !== 8'hAA || busy !== 1'b1) begin
         failed++;
         $display("FAIL reset_prefill: ov=%b od=%h busy=%b, expected 1 aa 1", out_valid, out_data, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
         failed++;
         $display("FAIL reset_async: ov=%b od=%h busy=%b ir=%b, expected 0 00 0 1",
                  out_valid, out_data, busy, in_ready);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      got.delete(); got_edge.delete();
      out_ready = 1'b1;
      send(PASS, 8'h00, 8'h11);
      idle(5);
      check_seq("reset_first_beat", '{8'h11});
   endtask

   task automatic test_inv_back_to_back();
      int acc0;
      do_reset();
      out_ready = 1'b1;
      send(INV, 8'hFF, 8'h00);
      acc0 = last_acc_edge;
      send(INV, 8'hFF, 8'h01);
      send(INV, 8'hFF, 8'hA5);
      idle(5);
      check_seq("inv", '{8'hFF, 8'hFE, 8'h5A});
      if (got_edge.size() == 3) begin
         tests++;
         if (got_edge[0] - acc0 != 2) begin
            failed++;
            $display("FAIL inv_latency: got %0d edges, expected 2", got_edge[0] - acc0);
         end
         tests++;
         if (got_edge[1] != got_edge[0] + 1 || got_edge[2] != got_edge[1] + 1) begin
            failed++;
            $display("FAIL inv_throughput: edges %0d %0d %0d, expected consecutive",
                     got_edge[0], got_edge[1], got_edge[2]);
         end
      end
   endtask

   task automatic test_edge();
      do_reset();
      out_ready = 1'b1;
      send(EDGE, 8'h00, 8'h0F);
      send(EDGE, 8'h00, 8'h0F);
      send(EDGE, 8'h00, 8'hF0);
      send(EDGE, 8'h00, 8'h00);
      idle(5);
      check_seq("edge", '{8'h0F, 8'h00, 8'hFF, 8'hF0});
   endtask

   task automatic test_alt();
      do_reset();
      out_ready = 1'b1;
      repeat (4) send(ALT, 8'h0F, 8'h55);
      send(PASS, 8'h0F, 8'h55);
      // Sixth accept since reset, so phase is 1 here
      send(ALT, 8'h0F, 8'h55);
      idle(5);
      check_seq("alt", '{8'h55, 8'h5A, 8'h55, 8'h5A, 8'h55, 8'h5A});
   endtask

   task automatic test_backpressure();
      logic [7:0] vals [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      int idx = 0;
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 14; c++) begin
         in_valid = 1'b1;
         in_data = vals[idx];
         cfg_mode = PASS;
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         if (c >= 4) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== 8'h01 || in_ready !== 1'b0) begin
               failed++;
               $display("FAIL bp_hold: ov=%b od=%h ir=%b, expected 1 01 0", out_valid, out_data, in_ready);
            end
         end
         @(posedge clk); #1;
      end
      tests++;
      if (idx != 2) begin
         failed++;
         $display("FAIL bp_accepted: got %0d, expected 2", idx);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && idx < 5; c++) begin
         in_valid = 1'b1;
         in_data = vals[idx];
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         @(posedge clk); #1;
      end
      idle(5);
      check_seq("bp_drain", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      logic [7:0] mprev = 8'h00;
      logic       mphase = 1'b0;
      logic [7:0] y;
      logic       hold = 1'b0;
      logic [7:0] hd = 8'h00;
      int sent = 0;
      int ncyc = 0;
      do_reset();
      while (got.size() < 1000 && ncyc < 20000) begin
         in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
         cfg_mode = 2'($urandom_range(0, 3));
         cfg_mask = 8'($urandom);
         in_data = 8'($urandom);
         out_ready = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         if (hold) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== hd) begin
               failed++;
               $display("FAIL rand_stable: ov=%b od=%h, expected 1 %h", out_valid, out_data, hd);
            end
         end
         hold = out_valid && !out_ready;
         hd = out_data;
         if (in_valid && in_ready) begin
            case (cfg_mode)
               PASS:    y = in_data;
               INV:     y = in_data ^ cfg_mask;
               EDGE:    y = in_data ^ mprev;
               default: y = mphase ? (in_data ^ cfg_mask) : in_data;
            endcase
            exp_q.push_back(y);
            mprev = in_data;
            mphase = ~mphase;
            sent++;
         end
         @(posedge clk); #1;
         ncyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tests++;
      if (got.size() != 1000) begin
         failed++;
         $display("FAIL rand_count: got %0d beats, expected 1000", got.size());
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         tests++;
         if (got[i] !== exp_q[i]) begin
            failed++;
            $display("FAIL rand_data[%0d]: got %h, expected %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_inv_back_to_back();
      test_edge();
      test_alt();
      test_backpressure();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
